// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package wb_arb_pkg;
  localparam int XLEN             = 32;
  localparam int REG_ADDR_W       = 5;
  localparam int DEF_DEPTH        = 2;
  localparam int DEF_STARVE_LIMIT = 8;
  localparam int DEF_CNT_W        = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO buffering long-latency-unit results.
// With WB_PORT_SCOREBOARD_EN it also exposes a mask of pending destination registers.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
`ifdef WB_PORT_SCOREBOARD_EN
  ,
  output logic [XLEN-1:0] pending_mask
`endif
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty when the slots match.
  logic [AW:0] wptr, rptr;
  wb_entry_t   mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_entry;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

`ifdef WB_PORT_SCOREBOARD_EN
  logic [AW:0]   count;
  logic [AW-1:0] slot;

  assign count = wptr - rptr;

  // Only slots between read and write pointer hold live entries.
  always_comb begin
    pending_mask = '0;
    slot         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rptr[AW-1:0] + AW'(i);
      if ((AW+1)'(i) < count) pending_mask[mem[slot].rd] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end
`endif
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, LU results drain into idle cycles.
// Optional pending-register mask output enabled by WB_PORT_SCOREBOARD_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  lu_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wd,
  output logic                  stall_req
`ifdef WB_PORT_SCOREBOARD_EN
  ,
  output logic [XLEN-1:0]       pending_mask
`endif
);
  logic      pw;
  logic      full, empty;
  logic      push, pop;
  wb_entry_t head;
  logic [CNT_W-1:0] wait_cnt;

  // A write to x0 is a no-op, so that cycle is free for the FIFO.
  assign pw       = RegWriteW && (RdW != '0);
  assign lu_ready = rst && !full;
  assign push     = lu_valid && lu_ready && (lu_rd != '0);
  assign pop      = !pw && !empty;

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{rd: lu_rd, data: lu_data}),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head)
`ifdef WB_PORT_SCOREBOARD_EN
    ,
    .pending_mask (pending_mask)
`endif
  );

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (rst) begin
      if (pw) begin
        rf_we = 1'b1;
        rf_rd = RdW;
        rf_wd = ResultW;
      end else if (!empty) begin
        rf_we = 1'b1;
        rf_rd = head.rd;
        rf_wd = head.data;
      end
    end
  end

  // Counts cycles the head is denied the port; saturates so stall_req holds until it pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (empty || pop) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_W'(STARVE_LIMIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign stall_req = (wait_cnt == CNT_W'(STARVE_LIMIT));
endmodule
